// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the SRAM port arbiter: FSM states, access owner,
// and the width helper used to size the latency counter.
`timescale 1ns/1ps
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_MEM  = 2'd2
  } owner_t;

  // Width able to hold SRAM_LATENCY-1, never narrower than one bit.
  function automatic int cnt_width(input int lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_wait_counter.sv
// Loadable down-counter that times one SRAM access; zero marks the
// final cycle the SRAM enable is held.
`timescale 1ns/1ps
module wait_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] cnt,
  output logic             zero
);

  // Load on a new grant, otherwise count down and stop at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && !zero) begin
      cnt <= cnt - WIDTH'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port SRAM between instruction fetch and the MEM
// stage. MEM has priority; IF is granted after STARVE_LIMIT consecutive
// MEM grants made while it was waiting. Each access holds the SRAM enable
// for SRAM_LATENCY cycles and ends with a one-cycle ready pulse.
`timescale 1ns/1ps
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int SRAM_LATENCY = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_cancel,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ready,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              if_freeze,
  output logic              pipe_freeze,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam int CNT_W = cnt_width(SRAM_LATENCY);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SRAM_LATENCY - 1);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

  state_t           state, state_nxt;
  owner_t           owner, owner_nxt;
  logic [STV_W-1:0] starve_cnt, starve_nxt;
  logic             cancel_q;
  logic             if_want;
  logic             grant_if, grant_mem;
  logic             done;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;

  // A fetch cancelled this cycle is not a candidate for a grant.
  assign if_want = if_req & ~if_cancel;
  assign done    = (state == ST_ACCESS) & cnt_zero;

  wait_counter #(.WIDTH(CNT_W)) u_wait_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (grant_if | grant_mem),
    .load_val (CNT_LOAD),
    .dec      (state == ST_ACCESS),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  // State, owner and starvation counter registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      owner      <= OWN_NONE;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  // Next-state logic and grant decision; grants are only made in IDLE.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // can leave a value unassigned and infer a latch.
    state_nxt  = state;
    owner_nxt  = owner;
    starve_nxt = starve_cnt;
    grant_if   = 1'b0;
    grant_mem  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mem_req && if_want && starve_cnt == STV_MAX) grant_if = 1'b1;
        else if (mem_req)                                grant_mem = 1'b1;
        else if (if_want)                                grant_if = 1'b1;

        if (grant_if) begin
          state_nxt  = ST_ACCESS;
          owner_nxt  = OWN_IF;
          starve_nxt = '0;
        end else if (grant_mem) begin
          state_nxt = ST_ACCESS;
          owner_nxt = OWN_MEM;
          if (!if_want)                  starve_nxt = '0;
          else if (starve_cnt != STV_MAX) starve_nxt = starve_cnt + STV_W'(1);
        end
      end
      ST_ACCESS: begin
        if (cnt_zero) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        state_nxt = ST_IDLE;
        owner_nxt = OWN_NONE;
      end
      default: begin
        state_nxt = ST_IDLE;
        owner_nxt = OWN_NONE;
      end
    endcase
  end

  // SRAM request registers, read-data capture and the fetch-cancel flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      sram_en    <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      if_rdata   <= '0;
      mem_rdata  <= '0;
      cancel_q   <= 1'b0;
    end else begin
      if (grant_if || grant_mem) begin
        sram_en    <= 1'b1;
        sram_we    <= grant_mem & mem_we;
        sram_addr  <= grant_mem ? mem_addr : if_addr;
        sram_wdata <= grant_mem ? mem_wdata : '0;
        cancel_q   <= 1'b0;
      end else if (done) begin
        sram_en <= 1'b0;
        sram_we <= 1'b0;
        if (owner == OWN_IF)  if_rdata  <= sram_rdata;
        if (owner == OWN_MEM) mem_rdata <= sram_rdata;
      end
      // A cancelled fetch still completes on the SRAM but is never reported.
      if (if_cancel && owner == OWN_IF && state != ST_IDLE) cancel_q <= 1'b1;
    end
  end

  assign if_ready    = (state == ST_RESP) & (owner == OWN_IF) & ~cancel_q & ~if_cancel;
  assign mem_ready   = (state == ST_RESP) & (owner == OWN_MEM);
  assign if_freeze   = if_req  & ~if_ready  & ~rst;
  assign pipe_freeze = mem_req & ~mem_ready & ~rst;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a LAT=4 instance backed by a small
// SRAM model, and a LAT=1 instance backed by a read-only pattern.
// Unwritten SRAM words read as 0xA0000000 + word index.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // LAT=4 instance
  logic        rst, if_req, if_cancel, mem_req, mem_we;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic        if_ready, mem_ready, if_freeze, pipe_freeze, sram_en, sram_we;
  logic [31:0] if_rdata, mem_rdata, sram_addr, sram_wdata, sram_rdata;

  // LAT=1 instance
  logic        b_rst, b_if_req, b_if_cancel, b_mem_req, b_mem_we;
  logic [31:0] b_if_addr, b_mem_addr, b_mem_wdata;
  logic        b_if_ready, b_mem_ready, b_if_freeze, b_pipe_freeze, b_sram_en, b_sram_we;
  logic [31:0] b_if_rdata, b_mem_rdata, b_sram_addr, b_sram_wdata, b_sram_rdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .SRAM_LATENCY(4), .STARVE_LIMIT(4)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
    .if_ready(if_ready), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .if_freeze(if_freeze), .pipe_freeze(pipe_freeze),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .SRAM_LATENCY(1), .STARVE_LIMIT(4)) u_dut_lat1 (
    .clk(clk), .rst(b_rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_cancel(b_if_cancel),
    .if_ready(b_if_ready), .if_rdata(b_if_rdata),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_ready(b_mem_ready), .mem_rdata(b_mem_rdata),
    .if_freeze(b_if_freeze), .pipe_freeze(b_pipe_freeze),
    .sram_en(b_sram_en), .sram_we(b_sram_we), .sram_addr(b_sram_addr),
    .sram_wdata(b_sram_wdata), .sram_rdata(b_sram_rdata)
  );

  // SRAM model: filled with the pattern on the first edge, then written on en&we.
  logic [31:0] sram [0:255];
  logic        sram_filled = 1'b0;
  always @(posedge clk) begin
    if (!sram_filled) begin
      for (int i = 0; i < 256; i++) sram[i] <= 32'hA000_0000 + 32'(i);
      sram_filled <= 1'b1;
    end else if (sram_en && sram_we) begin
      sram[sram_addr[9:2]] <= sram_wdata;
    end
  end
  assign sram_rdata   = sram[sram_addr[9:2]];
  assign b_sram_rdata = 32'hA000_0000 + {24'd0, b_sram_addr[9:2]};

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; b_rst = 1'b1;
    if_req = 1'b1; if_addr = '0; if_cancel = 1'b0;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    b_if_req = 1'b0; b_if_addr = '0; b_if_cancel = 1'b0;
    b_mem_req = 1'b1; b_mem_we = 1'b0; b_mem_addr = '0; b_mem_wdata = '0;
    cyc(); cyc(); mid();
    n_total++; if (sram_en !== 1'b0) $display("FAIL reset sram_en: got %b want 0", sram_en); else n_pass++;
    n_total++; if (sram_we !== 1'b0) $display("FAIL reset sram_we: got %b want 0", sram_we); else n_pass++;
    n_total++; if (if_ready !== 1'b0) $display("FAIL reset if_ready: got %b want 0", if_ready); else n_pass++;
    n_total++; if (mem_ready !== 1'b0) $display("FAIL reset mem_ready: got %b want 0", mem_ready); else n_pass++;
    n_total++; if (if_freeze !== 1'b0) $display("FAIL reset if_freeze: got %b want 0", if_freeze); else n_pass++;
    n_total++; if (pipe_freeze !== 1'b0) $display("FAIL reset pipe_freeze: got %b want 0", pipe_freeze); else n_pass++;
    n_total++; if (b_pipe_freeze !== 1'b0) $display("FAIL reset lat1 pipe_freeze: got %b want 0", b_pipe_freeze); else n_pass++;
    n_total++; if (sram_addr !== 32'h0) $display("FAIL reset sram_addr: got %h want 0", sram_addr); else n_pass++;
    n_total++; if (if_rdata !== 32'h0) $display("FAIL reset if_rdata: got %h want 0", if_rdata); else n_pass++;
    n_total++; if (mem_rdata !== 32'h0) $display("FAIL reset mem_rdata: got %h want 0", mem_rdata); else n_pass++;
    cyc();
    rst = 1'b0; b_rst = 1'b0;
    if_req = 1'b0; mem_req = 1'b0; b_mem_req = 1'b0;
    cyc(); cyc();
  endtask

  task automatic test_if_fetch();
    logic e;
    if_req = 1'b1; if_addr = 32'h0;
    for (int c = 0; c <= 6; c++) begin
      if (c == 6) if_req = 1'b0;
      mid();
      e = (c >= 1 && c <= 4);
      n_total++; if (sram_en !== e) $display("FAIL if_fetch sram_en c%0d: got %b want %b", c, sram_en, e); else n_pass++;
      e = (c == 5);
      n_total++; if (if_ready !== e) $display("FAIL if_fetch if_ready c%0d: got %b want %b", c, if_ready, e); else n_pass++;
      e = (c <= 4);
      n_total++; if (if_freeze !== e) $display("FAIL if_fetch if_freeze c%0d: got %b want %b", c, if_freeze, e); else n_pass++;
      if (c == 1) begin
        n_total++; if (sram_we !== 1'b0) $display("FAIL if_fetch sram_we: got %b want 0", sram_we); else n_pass++;
        n_total++; if (sram_addr !== 32'h0) $display("FAIL if_fetch sram_addr: got %h want 0", sram_addr); else n_pass++;
      end
      if (c == 5) begin
        n_total++; if (if_rdata !== 32'hA000_0000) $display("FAIL if_fetch if_rdata: got %h want a0000000", if_rdata); else n_pass++;
      end
      cyc();
    end
  endtask

  task automatic test_mem_priority();
    logic e;
    for (int c = 0; c <= 18; c++) begin
      if (c == 0) begin
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h40; mem_wdata = 32'hDEAD_BEEF;
        if_req = 1'b1; if_addr = 32'h44;
      end
      if (c == 6)  begin mem_req = 1'b0; mem_we = 1'b0; end
      if (c == 12) begin if_req = 1'b0; mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h40; end
      if (c == 18) mem_req = 1'b0;
      mid();
      e = (c == 5 || c == 17);
      n_total++; if (mem_ready !== e) $display("FAIL priority mem_ready c%0d: got %b want %b", c, mem_ready, e); else n_pass++;
      e = (c == 11);
      n_total++; if (if_ready !== e) $display("FAIL priority if_ready c%0d: got %b want %b", c, if_ready, e); else n_pass++;
      if (c == 1) begin
        n_total++; if ({sram_en, sram_we} !== 2'b11) $display("FAIL priority mem grant en/we: got %b want 11", {sram_en, sram_we}); else n_pass++;
        n_total++; if (sram_addr !== 32'h40) $display("FAIL priority mem addr: got %h want 40", sram_addr); else n_pass++;
        n_total++; if (sram_wdata !== 32'hDEAD_BEEF) $display("FAIL priority wdata: got %h want deadbeef", sram_wdata); else n_pass++;
      end
      if (c == 3) begin
        n_total++; if ({pipe_freeze, if_freeze} !== 2'b11) $display("FAIL priority freezes: got %b want 11", {pipe_freeze, if_freeze}); else n_pass++;
      end
      if (c == 5) begin
        n_total++; if (pipe_freeze !== 1'b0) $display("FAIL priority pipe_freeze at ready: got %b want 0", pipe_freeze); else n_pass++;
      end
      if (c == 7) begin
        n_total++; if ({sram_en, sram_we} !== 2'b10) $display("FAIL priority if grant en/we: got %b want 10", {sram_en, sram_we}); else n_pass++;
        n_total++; if (sram_addr !== 32'h44) $display("FAIL priority if addr: got %h want 44", sram_addr); else n_pass++;
      end
      if (c == 11) begin
        n_total++; if (if_rdata !== 32'hA000_0011) $display("FAIL priority if_rdata: got %h want a0000011", if_rdata); else n_pass++;
      end
      if (c == 17) begin
        n_total++; if (mem_rdata !== 32'hDEAD_BEEF) $display("FAIL priority readback: got %h want deadbeef", mem_rdata); else n_pass++;
      end
      cyc();
    end
  endtask

  task automatic test_starvation();
    logic [31:0] got_addr [10];
    int          got_cyc  [10];
    int          got;
    logic        prev_en;
    logic [31:0] want;
    got = 0;
    prev_en = 1'b0;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h80;
    if_req = 1'b1; if_addr = 32'h100;
    for (int c = 0; c < 100; c++) begin
      mid();
      if (sram_en && !prev_en) begin
        got_addr[got] = sram_addr;
        got_cyc[got]  = c;
        got++;
      end
      prev_en = sram_en;
      if (got == 10) break;
      cyc();
    end
    cyc();
    mem_req = 1'b0; if_req = 1'b0;
    for (int c = 0; c < 8; c++) cyc();
    n_total++; if (got !== 10) $display("FAIL starve grant count: got %0d want 10 within 100 cycles", got); else n_pass++;
    for (int g = 0; g < got; g++) begin
      want = ((g % 5) == 4) ? 32'h100 : 32'h80;
      n_total++; if (got_addr[g] !== want) $display("FAIL starve grant %0d addr: got %h want %h", g, got_addr[g], want); else n_pass++;
      if (g > 0) begin
        n_total++;
        if (got_cyc[g] - got_cyc[g-1] !== 6) $display("FAIL starve spacing %0d: got %0d want 6", g, got_cyc[g] - got_cyc[g-1]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_cancel();
    logic e;
    for (int c = 0; c <= 13; c++) begin
      if (c == 0)  begin if_req = 1'b1; if_addr = 32'h8; end
      if (c == 2)  begin if_cancel = 1'b1; if_req = 1'b0; end
      if (c == 3)  if_cancel = 1'b0;
      if (c == 6)  begin if_req = 1'b1; if_addr = 32'hC; end
      if (c == 12) begin if_req = 1'b1; if_addr = 32'h10; if_cancel = 1'b1; end
      if (c == 13) begin if_req = 1'b0; if_cancel = 1'b0; end
      mid();
      e = (c >= 1 && c <= 4) || (c >= 7 && c <= 10);
      n_total++; if (sram_en !== e) $display("FAIL cancel sram_en c%0d: got %b want %b", c, sram_en, e); else n_pass++;
      e = (c == 11);
      n_total++; if (if_ready !== e) $display("FAIL cancel if_ready c%0d: got %b want %b", c, if_ready, e); else n_pass++;
      if (c == 11) begin
        n_total++; if (if_rdata !== 32'hA000_0003) $display("FAIL cancel if_rdata: got %h want a0000003", if_rdata); else n_pass++;
      end
      cyc();
    end
  endtask

  task automatic test_reset_mid_access();
    logic e;
    for (int c = 0; c <= 14; c++) begin
      if (c == 0)  begin mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h48; mem_wdata = 32'h1234_5678; end
      if (c == 2)  rst = 1'b1;
      if (c == 3)  begin rst = 1'b0; mem_req = 1'b0; mem_we = 1'b0; end
      if (c == 8)  begin mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h4C; end
      if (c == 14) mem_req = 1'b0;
      mid();
      if (c == 1) begin
        n_total++; if ({sram_en, sram_we} !== 2'b11) $display("FAIL rst_mid started en/we: got %b want 11", {sram_en, sram_we}); else n_pass++;
      end
      if (c == 2) begin
        n_total++; if (pipe_freeze !== 1'b0) $display("FAIL rst_mid pipe_freeze in reset: got %b want 0", pipe_freeze); else n_pass++;
      end
      if (c == 3) begin
        n_total++; if ({sram_en, sram_we} !== 2'b00) $display("FAIL rst_mid aborted en/we: got %b want 00", {sram_en, sram_we}); else n_pass++;
        n_total++; if (mem_rdata !== 32'h0) $display("FAIL rst_mid mem_rdata cleared: got %h want 0", mem_rdata); else n_pass++;
        n_total++; if (if_rdata !== 32'h0) $display("FAIL rst_mid if_rdata cleared: got %h want 0", if_rdata); else n_pass++;
      end
      if (c >= 3 && c <= 8) begin
        n_total++; if (sram_en !== 1'b0) $display("FAIL rst_mid idle sram_en c%0d: got %b want 0", c, sram_en); else n_pass++;
      end
      if (c == 9) begin
        n_total++; if (sram_en !== 1'b1) $display("FAIL rst_mid next grant sram_en: got %b want 1", sram_en); else n_pass++;
      end
      e = (c == 13);
      n_total++; if (mem_ready !== e) $display("FAIL rst_mid mem_ready c%0d: got %b want %b", c, mem_ready, e); else n_pass++;
      if (c == 13) begin
        n_total++; if (mem_rdata !== 32'hA000_0013) $display("FAIL rst_mid mem_rdata: got %h want a0000013", mem_rdata); else n_pass++;
      end
      cyc();
    end
  endtask

  task automatic test_back_to_back_lat1();
    logic e;
    for (int c = 0; c <= 9; c++) begin
      if (c == 0) begin b_mem_req = 1'b1; b_mem_addr = 32'h10; end
      if (c == 9) b_mem_req = 1'b0;
      mid();
      if (c <= 8) begin
        e = ((c % 3) == 2);
        n_total++; if (b_mem_ready !== e) $display("FAIL lat1 mem_ready c%0d: got %b want %b", c, b_mem_ready, e); else n_pass++;
        n_total++; if (b_pipe_freeze !== !e) $display("FAIL lat1 pipe_freeze c%0d: got %b want %b", c, b_pipe_freeze, !e); else n_pass++;
        e = ((c % 3) == 1);
        n_total++; if (b_sram_en !== e) $display("FAIL lat1 sram_en c%0d: got %b want %b", c, b_sram_en, e); else n_pass++;
      end
      if (c == 1) begin
        n_total++; if ({b_sram_we, b_sram_wdata} !== 33'h0) $display("FAIL lat1 read we/wdata: got %b/%h want 0/0", b_sram_we, b_sram_wdata); else n_pass++;
      end
      if (c == 2) begin
        n_total++; if (b_mem_rdata !== 32'hA000_0004) $display("FAIL lat1 mem_rdata: got %h want a0000004", b_mem_rdata); else n_pass++;
      end
      if (c == 9) begin
        n_total++;
        if ({b_if_ready, b_if_freeze, b_if_rdata} !== 34'h0)
          $display("FAIL lat1 if side idle: got %b/%b/%h want 0/0/0", b_if_ready, b_if_freeze, b_if_rdata);
        else n_pass++;
      end
      cyc();
    end
  endtask

  initial begin
    test_reset();
    test_if_fetch();
    test_mem_priority();
    test_starvation();
    test_cancel();
    test_reset_mid_access();
    test_back_to_back_lat1();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within 100000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
